// File: rtl/microseq_pkg.sv
// Shared definitions for the microcoded control unit:
// control-word bit indices and sequencer state encoding.
package microseq_pkg;

  localparam int HLT = 15;
  localparam int MI  = 14;
  localparam int RI  = 13;
  localparam int RO  = 12;
  localparam int IO  = 11;
  localparam int II  = 10;
  localparam int AI  = 9;
  localparam int AO  = 8;
  localparam int EO  = 7;
  localparam int SU  = 6;
  localparam int BI  = 5;
  localparam int OI  = 4;
  localparam int CE  = 3;
  localparam int CO  = 2;
  localparam int J   = 1;
  localparam int FI  = 0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

endpackage

// File: rtl/microseq_store.sv
// Writable microcode store: synchronous write, asynchronous read,
// contents survive reset.
module microseq_store
  import microseq_pkg::*;
#(
  parameter int AW = 9,
  parameter int DW = 17
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/microseq_ctrl.sv
// Microcoded sequencer: tick generation, step counter, halt FSM.
// Define INSTR_CNT_EN to build the retired-instruction counter.
module microseq_ctrl
  import microseq_pkg::*;
#(
  parameter int OPW     = 4,
  parameter int STEPW   = 3,
  parameter int NFLAGS  = 2,
  parameter int CWW     = 16,
  parameter int HLT_BIT = HLT,
  localparam int AW     = NFLAGS + OPW + STEPW
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              run_en,
  input  logic              step_req,
  input  logic [OPW-1:0]    opcode,
  input  logic [NFLAGS-1:0] flags,
  input  logic              ucode_we,
  input  logic [AW-1:0]     ucode_addr,
  input  logic [CWW:0]      ucode_wdata,
  output logic [CWW-1:0]    ctrl_word,
  output logic              tick,
  output logic [STEPW-1:0]  step,
  output logic              halted,
  output logic [15:0]       instr_cnt
);

  state_e           state_q, state_d;
  logic [STEPW-1:0] step_q, step_d;
  logic             req_q;
  logic             req_edge;
  logic [CWW:0]     rd_word;
  logic             nxt;
  logic             last;

  // A write coinciding with reset is dropped
  microseq_store #(
    .AW (AW),
    .DW (CWW + 1)
  ) u_store (
    .clk   (clk),
    .we    (ucode_we & clr),
    .waddr (ucode_addr),
    .wdata (ucode_wdata),
    .raddr ({flags, opcode, step_q}),
    .rdata (rd_word)
  );

  assign nxt      = rd_word[CWW];
  assign last     = nxt | (step_q == {STEPW{1'b1}});
  assign req_edge = step_req & ~req_q;

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= ST_RUN;
      step_q  <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      req_q   <= step_req;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    tick    = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        tick = run_en | req_edge;
        if (tick) begin
          if (rd_word[HLT_BIT]) state_d = ST_HALT;
          else if (last)        step_d  = '0;
          else                  step_d  = step_q + 1'b1;
        end
      end
      ST_HALT: begin
        tick = 1'b0;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign halted    = (state_q == ST_HALT);
  assign ctrl_word = halted ? '0 : rd_word[CWW-1:0];
  assign step      = step_q;

`ifdef INSTR_CNT_EN
  logic        retire;
  logic [15:0] cnt_q;

  assign retire = tick & ~rd_word[HLT_BIT] & last;

  always_ff @(posedge clk) begin
    if (!clr)        cnt_q <= '0;
    else if (retire) cnt_q <= cnt_q + 16'd1;
  end

  assign instr_cnt = cnt_q;
`else
  assign instr_cnt = 16'h0000;
`endif

endmodule
